// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the signals between the 5-stage pipeline datapath and the hazard /
// redirect controller.
//   master : pipeline side. Drives ID/EX/MEM status and receives the controls.
//   slave  : hazard controller. Receives status and drives the controls.
// Status (master -> slave):
//   id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i : ID source operands
//   ex_rd_i, ex_mem_read_i                           : EX destination / load flag
//   ex_branch_taken_i, ex_pc_new_i                   : EX redirect request
//   mem_busy_i                                       : data memory still busy
// Controls (slave -> master):
//   pc_select_o, pc_new_o                            : fetch redirect
//   pc_stall_o, ifid_stall_o, ifid_flush_o,
//   idex_stall_o, idex_flush_o, exmem_stall_o,
//   memwb_bubble_o                                   : pipeline register controls
//   hazard_state_o, stall_cnt_o, flush_cnt_o,
//   timeout_o                                        : status / performance
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_uses_rs1_i;
    logic             id_uses_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_mem_read_i;
    logic             ex_branch_taken_i;
    logic [XLEN-1:0]  ex_pc_new_i;
    logic             mem_busy_i;

    logic             pc_select_o;
    logic [XLEN-1:0]  pc_new_o;
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_stall_o;
    logic             idex_flush_o;
    logic             exmem_stall_o;
    logic             memwb_bubble_o;
    logic [1:0]       hazard_state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic             timeout_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_rd_i, ex_mem_read_i, ex_branch_taken_i, ex_pc_new_i,
               mem_busy_i,
        input  pc_select_o, pc_new_o, pc_stall_o, ifid_stall_o, ifid_flush_o,
               idex_stall_o, idex_flush_o, exmem_stall_o, memwb_bubble_o,
               hazard_state_o, stall_cnt_o, flush_cnt_o, timeout_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
               ex_rd_i, ex_mem_read_i, ex_branch_taken_i, ex_pc_new_i,
               mem_busy_i,
        output pc_select_o, pc_new_o, pc_stall_o, ifid_stall_o, ifid_flush_o,
               idex_stall_o, idex_flush_o, exmem_stall_o, memwb_bubble_o,
               hazard_state_o, stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard and redirect controller for the 5-stage RV32 pipeline.
// Resolves, in priority order: memory wait, replay of a redirect captured
// during a wait, a live EX redirect, and a load-use hazard. Controls are
// combinational (Mealy) from the inputs and the registered pending redirect.
// Also keeps saturating stall/redirect counters and a sticky memory-wait
// watchdog.
// Ports:
//   clk_i   : clock, all state updates on the rising edge
//   reset_i : synchronous active-low reset
//   hz      : slave side of pipeline_hazard_ctrl_if (status in, controls out)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int XLEN     = 32,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_NONE       = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_REDIRECT   = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } hazard_state_t;

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    hazard_state_t     state_q, state_d;
    logic              pend_q, pend_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    logic              pc_select;
    logic [XLEN-1:0]   pc_new;
    logic              pc_stall, ifid_stall, ifid_flush;
    logic              idex_stall, idex_flush, exmem_stall, memwb_bubble;
    logic              load_use;

    // x0 is never a real producer, so it cannot create a load-use hazard.
    assign load_use = hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0) &&
                      ((hz.id_uses_rs1_i && (hz.id_rs1_i == hz.ex_rd_i)) ||
                       (hz.id_uses_rs2_i && (hz.id_rs2_i == hz.ex_rd_i)));

    always_comb begin
        pc_select    = 1'b0;
        pc_new       = hz.ex_pc_new_i;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_stall  = 1'b0;
        memwb_bubble = 1'b0;
        state_d      = ST_NONE;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;

        if (!reset_i) begin
            pc_new = '0;
        end else if (hz.mem_busy_i) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = ST_MEM_WAIT;
            // The EX branch stays frozen during the wait; capture its target
            // once and replay it when memory finishes.
            if (hz.ex_branch_taken_i && !pend_q) begin
                pend_d    = 1'b1;
                pend_pc_d = hz.ex_pc_new_i;
            end
        end else if (pend_q) begin
            // The branch still showing in EX is the one already captured.
            pc_select  = 1'b1;
            pc_new     = pend_pc_q;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pend_d     = 1'b0;
            state_d    = ST_REDIRECT;
        end else if (hz.ex_branch_taken_i) begin
            pc_select  = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_REDIRECT;
        end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_LOAD_STALL;
        end

        stall_cnt_d = pc_stall  ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = pc_select ? sat_inc(flush_cnt_q) : flush_cnt_q;

        if (!hz.mem_busy_i) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
        // Flag on the same edge the counter reaches the limit.
        timeout_d = timeout_q || (hz.mem_busy_i && (wait_cnt_d == WAIT_MAX));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_NONE;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign hz.pc_select_o    = pc_select;
    assign hz.pc_new_o       = pc_new;
    assign hz.pc_stall_o     = pc_stall;
    assign hz.ifid_stall_o   = ifid_stall;
    assign hz.ifid_flush_o   = ifid_flush;
    assign hz.idex_stall_o   = idex_stall;
    assign hz.idex_flush_o   = idex_flush;
    assign hz.exmem_stall_o  = exmem_stall;
    assign hz.memwb_bubble_o = memwb_bubble;
    assign hz.hazard_state_o = state_q;
    assign hz.stall_cnt_o    = stall_cnt_q;
    assign hz.flush_cnt_o    = flush_cnt_q;
    assign hz.timeout_o      = timeout_q;

endmodule
